mem_access_seq: RTL
===================

Name: mem_access_seq

Overview:
- Parametrised memory-access sequencer between the multicycle RV32I/RV64I control FSM and the memory port.
- Accepts one load or store request at a time and handles the memory handshake. Generates the byte enable and aligned write data, and sign- or zero-extends load data.
- Detects misaligned and illegal-size accesses without touching memory. Also aborts accesses that wait longer than a set time-out.
- Replaces the hand-coded byte-enable and mem_resp wait loops in the control FSM.

Parameters:
- XLEN, 32, data width in bits; legal values are 32 and 64; NB = XLEN/8 and OFS = log2(NB).
- ADDR_W, 32, address width in bits.
- TIMEOUT, 255, the number of ACCESS cycles allowed without mem_resp before the access is aborted; 0 disables the time-out.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  [1:0] access size (0 = byte, 1 = half, 2 = word, 3 = double); [2] selects unsigned load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and on error.
- rsp_cause  out  2  0 = ok, 1 = misaligned, 2 = illegal size, 3 = time-out.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_W  address with the low OFS bits forced to 0.
- mem_byte_enable  out  NB  byte lanes.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_rdata  in  XLEN  read data.
- mem_resp  in  1  memory done.
- stat_accesses  out  32  see Optional Feature.
- stat_stalls  out  32  see Optional Feature.

Behaviour:
- Reset: state IDLE and all outputs 0, except req_ready, which is 1. rst asserted mid-access drops mem_read/mem_write immediately (asynchronously); no response is issued.
- The request fields are captured on the edge where req_valid && req_ready (cycle T).
- Size check: size > OFS gives illegal size (code 2). Size 3 is always illegal when XLEN = 32.
- Alignment check: the access is misaligned (code 1) when addr[size-1:0] != 0.
- States:
  - IDLE: req_ready = 1. On accept, go to RESP if the size check or alignment check fails; otherwise go to ACCESS.
  - ACCESS: mem_read = !write and mem_write = write, both held steady. mem_address, mem_byte_enable and mem_wdata are stable.
    - On mem_resp = 1: capture mem_rdata and go to RESP with code 0.
    - If TIMEOUT != 0 and the wait counter reaches TIMEOUT without mem_resp: go to RESP with code 3.
  - RESP: rsp_valid = 1 for exactly one cycle, then IDLE. req_ready = 0.
- mem_read/mem_write decode combinationally from state; they are 0 in IDLE and RESP. Memory strobes never assert for an erroneous request.
- Latency:
  - Error case: rsp_valid at T+1.
  - Good case: mem_resp in the k-th ACCESS cycle (k ≥ 1) gives rsp_valid in cycle T+k+1.
  - Next accept is possible at T+k+2 at the earliest.
- mem_resp arriving in the same cycle the wait counter hits TIMEOUT: mem_resp wins (code 0).
- Wait counter: clears on entry to ACCESS and counts each ACCESS cycle without mem_resp. Its width is enough to hold TIMEOUT.
- Lanes: let off = addr[OFS-1:0].
  - mem_byte_enable = ((1 << (1 << size)) - 1) << off.
  - mem_wdata = req_wdata << (8*off).
- Load data: shift mem_rdata right by 8*off and keep the low 8 << size bits.
  - If funct3[2] = 0, sign-extend to XLEN; otherwise zero-extend.
  - funct3 = 3'b111 is an illegal size.
- mem_resp or mem_rdata seen outside ACCESS is ignored.

Optional Feature:
- Macro: MEM_ACCESS_STATS_EN.
- Defined:
  - stat_accesses increments on each entry to RESP with code 0.
  - stat_stalls increments on each ACCESS cycle with mem_resp = 0.
  - Both counters wrap at 2^32 and are cleared by rst.
- Undefined: both ports are constant 0 and no counter logic is generated.

Test Plan:
- XLEN = 32, load lb, addr 0x1003, mem_rdata 0x80FF_FF_FF, mem_resp on the 2nd ACCESS cycle → mem_byte_enable 4'b1000, mem_address 0x1000, rsp_rdata 0xFFFFFF80, rsp_cause 0, rsp_valid at T+3.
- Store sh, addr 0x2002, wdata 0x0000BEEF → mem_write = 1, mem_byte_enable 4'b1100, mem_wdata 0xBEEF0000. After mem_resp: rsp_valid with rsp_rdata 0.
- Load lw at 0x1002; then store sd (funct3 = 3) with XLEN = 32 → codes 1 and 2 respectively at T+1; mem_read and mem_write stay 0 throughout.
- TIMEOUT = 4 with mem_resp never asserted → mem_read high for exactly 4 cycles, then rsp_cause 3. Repeat with mem_resp in the 4th cycle → code 0.
- XLEN = 64, load lwu, addr 0x...4, mem_rdata 0x8765_4321_0000_0000 → mem_byte_enable 8'hF0, rsp_rdata 0x0000_0000_8765_4321.
- rst pulsed during ACCESS → mem_read falls in the same cycle, no rsp_valid, and req_ready = 1 once rst deasserts. With MEM_ACCESS_STATS_EN, stat counters read 0 after the reset.

Source files
------------

// File: rtl/mem_access_seq.sv
// mem_access_seq: single-outstanding load/store sequencer between the
// multicycle control FSM and the memory port. It generates byte enables and
// lane-shifted store data, extends load data, rejects misaligned or
// illegal-size requests without touching memory, and aborts accesses that
// wait too long for mem_resp.
//
// Optional build macro: MEM_ACCESS_STATS_EN
//   defined   -> stat_accesses / stat_stalls are live 32-bit wrapping counters
//   undefined -> both stat ports tie to 0 and no counter logic exists
module mem_access_seq #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_cause,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [XLEN/8-1:0] mem_byte_enable,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp,
  output logic [31:0]       stat_accesses,
  output logic [31:0]       stat_stalls
);

  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);
  // Wait counter only needs to reach TIMEOUT-1; the abort fires on that cycle.
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0]    OFS2    = 2'(OFS);

  localparam logic [1:0] C_OK      = 2'd0;
  localparam logic [1:0] C_MISAL   = 2'd1;
  localparam logic [1:0] C_ILLEGAL = 2'd2;
  localparam logic [1:0] C_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured request and response registers
  logic              r_write;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;
  logic [1:0]        r_cause;
  logic [CW-1:0]     r_cnt;

  // Request decode (evaluated on the live request fields)
  logic [1:0] w_req_size;
  logic [2:0] w_req_amask;
  logic       w_req_illegal;
  logic       w_req_misal;
  logic       w_req_err;
  logic       w_accept;
  logic       w_timeout;

  // Datapath from the captured request
  logic [1:0]        w_size;
  logic [OFS-1:0]    w_off;
  logic [NB-1:0]     w_be;
  logic [XLEN-1:0]   w_wdata_sh;
  logic [ADDR_W-1:0] w_addr_aligned;
  logic [XLEN-1:0]   w_rdata_sh;
  logic [XLEN-1:0]   w_keep;
  logic              w_sign;
  logic [XLEN-1:0]   w_load_ext;

  assign w_req_size = req_funct3[1:0];
  assign w_accept   = req_valid && (r_state == S_IDLE);

  // Alignment mask for the requested size: addr bits that must be zero
  always_comb begin
    w_req_amask = 3'b000;
    case (w_req_size)
      2'd0:    w_req_amask = 3'b000;
      2'd1:    w_req_amask = 3'b001;
      2'd2:    w_req_amask = 3'b011;
      default: w_req_amask = 3'b111;
    endcase
  end

  // Size check wins over alignment; funct3=111 has no legal meaning
  assign w_req_illegal = (w_req_size > OFS2) || (req_funct3 == 3'b111);
  assign w_req_misal   = (req_addr[2:0] & w_req_amask) != 3'b000;
  assign w_req_err     = w_req_illegal || w_req_misal;

  // Abort on the TIMEOUT-th ACCESS cycle without mem_resp (never if TIMEOUT=0)
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  assign w_size         = r_funct3[1:0];
  assign w_off          = r_addr[OFS-1:0];
  assign w_addr_aligned = {r_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
  assign w_wdata_sh     = r_wdata << {w_off, 3'b000};
  assign w_rdata_sh     = mem_rdata >> {w_off, 3'b000};

  // Byte lane gi is enabled when it falls inside [off, off + bytes)
  for (genvar gi = 0; gi < NB; gi++) begin : g_be
    assign w_be[gi] = (32'(gi) >= 32'(w_off)) &&
                      (32'(gi) < (32'(w_off) + (32'd1 << w_size)));
  end

  // Bits kept from the shifted load word: the low 8 << size bits
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_keep
    assign w_keep[gi] = 32'(gi) < (32'd8 << w_size);
  end

  // Sign bit of the extracted load value
  always_comb begin
    w_sign = 1'b0;
    case (w_size)
      2'd0:    w_sign = w_rdata_sh[7];
      2'd1:    w_sign = w_rdata_sh[15];
      2'd2:    w_sign = w_rdata_sh[31];
      default: w_sign = w_rdata_sh[XLEN-1];
    endcase
  end

  assign w_load_ext = (w_rdata_sh & w_keep) |
                      ((w_sign && !r_funct3[2]) ? ~w_keep : '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_state_next = w_req_err ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        if (mem_resp || w_timeout) w_state_next = S_RESP;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode: strobes and lanes only in ACCESS, response only in RESP
  always_comb begin
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_rdata       = '0;
    rsp_cause       = C_OK;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_byte_enable = '0;
    mem_wdata       = '0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_ACCESS: begin
        mem_read        = !r_write;
        mem_write       = r_write;
        mem_address     = w_addr_aligned;
        mem_byte_enable = w_be;
        mem_wdata       = w_wdata_sh;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = r_rdata;
        rsp_cause = r_cause;
      end
      default: ;
    endcase
  end

  // Request capture and response data/cause update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cause  <= C_OK;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_rdata  <= '0;
      r_cause  <= w_req_illegal ? C_ILLEGAL : (w_req_misal ? C_MISAL : C_OK);
    end else if (r_state == S_ACCESS) begin
      if (mem_resp) begin
        r_rdata <= r_write ? '0 : w_load_ext;
        r_cause <= C_OK;
      end else if (w_timeout) begin
        r_cause <= C_TIMEOUT;
      end
    end
  end

  // Wait counter: cleared at accept, counts ACCESS cycles without mem_resp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !mem_resp) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] r_stat_accesses;
  logic [31:0] r_stat_stalls;

  // Completed-access and stall counters, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_accesses <= 32'd0;
      r_stat_stalls   <= 32'd0;
    end else if (r_state == S_ACCESS) begin
      if (mem_resp) r_stat_accesses <= r_stat_accesses + 32'd1;
      else          r_stat_stalls   <= r_stat_stalls + 32'd1;
    end
  end

  assign stat_accesses = r_stat_accesses;
  assign stat_stalls   = r_stat_stalls;
`else
  assign stat_accesses = 32'd0;
  assign stat_stalls   = 32'd0;
`endif

endmodule
